// File: rtl/audio_pkg.sv
// audio_pkg: shared state encoding, field widths and the rest code for the audio arbiter
package audio_pkg;
    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_e;
    localparam int NOTE_W = 8;
    localparam int LEN_W = 8;
    localparam logic [NOTE_W-1:0] NOTE_REST = '0;
endpackage

// File: rtl/priority_picker.sv
// priority_picker: fixed-priority select, lowest set index wins
module priority_picker #(
    parameter int N = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    output logic [N-1:0]  oh,
    output logic [IW-1:0] idx,
    output logic          any
);
    assign oh = req & (~req + 1'b1);
    assign any = |req;
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) idx = req[i] ? IW'(i) : idx;
    end
endmodule

// File: rtl/audio_arbiter.sv
// audio_arbiter: fixed-priority, preemptive owner of a tone generator with tick-timed note durations
module audio_arbiter
    import audio_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int TICK_BITS = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*NOTE_W-1:0]  req_note,
    input  logic [NREQ*LEN_W-1:0]   req_len,
    output logic [NREQ-1:0]         req_ready,
    output logic [NREQ-1:0]         grant,
    output logic [NOTE_W-1:0]       note_out,
    output logic [NREQ-1:0]         done
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    state_e                state_q, state_d;
    logic [TICK_BITS-1:0]  pre_q, pre_d;
    logic [LEN_W-1:0]      rem_q, rem_d, win_len;
    logic [NOTE_W-1:0]     note_out_q, note_out_d, win_note;
    logic [IW-1:0]         own_q, own_d, win_idx;
    logic [NREQ-1:0]       grant_q, grant_d, done_q, done_d, win_oh;
    logic                  win_any, ready_en, xfer, tick;
    priority_picker #(.N(NREQ), .IW(IW)) u_pick (
        .req(req_valid),
        .oh(win_oh),
        .idx(win_idx),
        .any(win_any)
    );
    assign win_note = req_note[win_idx*NOTE_W +: NOTE_W];
    assign win_len = req_len[win_idx*LEN_W +: LEN_W];
    // Only a strictly higher-priority requester may cut into a playing note; GAP never accepts.
    assign ready_en = rst_n & ((state_q == IDLE) | ((state_q == PLAY) & (win_idx < own_q)));
    assign req_ready = ready_en ? win_oh : '0;
    assign xfer = win_any & ready_en;
    assign tick = &pre_q;
    always_comb begin
        state_d = state_q;
        pre_d = (state_q == IDLE) ? '0 : pre_q + 1'b1;
        rem_d = rem_q;
        note_out_d = note_out_q;
        own_d = own_q;
        grant_d = grant_q;
        done_d = '0;
        if (state_q == PLAY && tick) begin
            rem_d = rem_q - 1'b1;
            if (rem_q == LEN_W'(1)) begin
                done_d = grant_q;
                grant_d = '0;
                note_out_d = NOTE_REST;
                state_d = GAP;
            end
        end
        if (state_q == GAP && tick) state_d = IDLE;
        if (xfer) begin
            pre_d = '0;
            done_d = (win_len == '0) ? win_oh : '0;
            rem_d = win_len;
            own_d = win_idx;
            grant_d = (win_len == '0) ? '0 : win_oh;
            note_out_d = (win_len == '0) ? NOTE_REST : win_note;
            state_d = (win_len == '0) ? IDLE : PLAY;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pre_q <= '0;
            rem_q <= '0;
            note_out_q <= NOTE_REST;
            own_q <= '0;
            grant_q <= '0;
            done_q <= '0;
        end else begin
            state_q <= state_d;
            pre_q <= pre_d;
            rem_q <= rem_d;
            note_out_q <= note_out_d;
            own_q <= own_d;
            grant_q <= grant_d;
            done_q <= done_d;
        end
    end
    assign grant = grant_q;
    assign note_out = note_out_q;
    assign done = done_q;
endmodule

// File: doc/audio_arbiter.md
AUDIO_ARBITER -- requirements
Module: audio_arbiter

Interface
REQ-001 Parameter NREQ, default 3: number of note requesters; index 0 has the highest priority.
REQ-002 Parameter TICK_BITS, default 16: one duration tick is 2^TICK_BITS clk cycles.
REQ-003 clk  input  1  sole clock; all state is updated on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  input  NREQ  per-requester note request.
REQ-006 req_note  input  NREQ*8  per-requester note code; slice i is bits [8i+7:8i]; code 0 means rest.
REQ-007 req_len  input  NREQ*8  per-requester duration in ticks; slice i is bits [8i+7:8i].
REQ-008 req_ready  output  NREQ  accept strobe: at most one bit high per cycle.
REQ-009 grant  output  NREQ  one-hot owner of the tone generator; all zero when no owner.
REQ-010 note_out  output  8  note code driven to the tone generator; 0 means silent.
REQ-011 done  output  NREQ  one-cycle pulse when the granted note completes its full duration.

Function
REQ-012 States: IDLE, PLAY, GAP.
REQ-013 Winner = lowest index i with req_valid[i]=1.
REQ-014 req_ready[winner] is asserted combinationally only in IDLE, or in PLAY when the winner index is strictly lower than the current owner.
REQ-015 Transfer occurs on req_valid[i] & req_ready[i]; a requester holds valid, note and len stable until that transfer.
REQ-016 On transfer: latch note and len, set grant to one-hot i, clear the prescaler to 0, enter PLAY on the next cycle.
REQ-017 The prescaler counts clk in PLAY and GAP only; tick = (prescaler == 2^TICK_BITS-1), after which it wraps to 0.
REQ-018 PLAY drives note_out = latched note (0 for a rest) and decrements remaining length on each tick.
REQ-019 When a tick decrements remaining from 1 to 0: done[owner] pulses for 1 cycle, grant clears, note_out = 0, enter GAP.
REQ-020 GAP lasts exactly 1 tick with note_out = 0, then enters IDLE.
REQ-021 GAP accepts no requests, including higher-priority ones.
REQ-022 Note duration is exactly len*2^TICK_BITS cycles, measured from the first PLAY cycle.
REQ-023 len = 0 on transfer: stay in IDLE, pulse done[i] on the next cycle, leave note_out at 0.
REQ-024 Preemption in PLAY: the old owner gets no done pulse, and the new note's latch and prescaler clear take effect on the transfer cycle.
REQ-025 Preemption timing: grant and note_out switch on the next cycle with no GAP inserted.
REQ-026 A requester that drops valid before transfer is never granted; no state change results.
REQ-027 A valid from the current owner during PLAY is ignored until the arbiter next returns to IDLE.

Reset
REQ-028 On rst_n low: state = IDLE, prescaler = 0, remaining = 0, latched note = 0, grant = 0, note_out = 0, done = 0, req_ready = 0.
REQ-029 Reset mid-PLAY silences note_out immediately (asynchronously); no done pulse is issued.
REQ-030 On release: the first transfer is possible in the first clk edge after deassertion.

Structure
REQ-031 Shared package audio_pkg holds:
- the state enum (IDLE/PLAY/GAP);
- NOTE_W = 8 and LEN_W = 8;
- the NOTE_REST = 0 constant.
REQ-032 Fixed-priority selection is a sub-module priority_picker (NREQ-wide in, one-hot plus index out).
REQ-033 All outputs except req_ready are registered; total RTL is 120-400 lines.

Verification (NREQ=3, TICK_BITS=2, one tick = 4 clk)
REQ-034 Single request: req 1 with note 0x25, len 3.
- Expect ready[1] for 1 cycle, then note_out = 0x25 for 12 cycles.
- Then done[1] pulses, note_out = 0 for 4 cycles (GAP), then IDLE.
REQ-035 Simultaneous requests: req 0 and req 2 valid in the same IDLE cycle.
- Expect grant = 3'b001 first; req 2 is accepted only after req 0's GAP ends.
REQ-036 Preemption: req 2 playing (len 5), req 0 (note 0x10, len 1) raised 6 cycles in.
- Expect no done[2], note_out = 0x10 on the next cycle for 4 cycles, then done[0].
REQ-037 Zero length: req 1 with len 0.
- Expect ready[1], done[1] on the next cycle, note_out stays 0, grant stays 0.
REQ-038 Reset during PLAY: rst_n pulled low mid-note.
- Expect note_out = 0 and grant = 0 without waiting for a clk edge.
- After release, a request is accepted on the first cycle.
REQ-039 Rest code: note 0 with len 2.
- Expect grant held and note_out = 0 for 8 cycles, then done pulses.
